// File: rtl/rand_delay_slice.sv
// ============================================================================
// Module      : rand_delay_slice
// Description : Single-entry valid/ready slice that holds each beat for
//               MIN_DELAY plus a masked LFSR slice of cycles before release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rand_delay_slice #(
    parameter int DATA_W    = 32,
    parameter int RAND_W    = 3,
    parameter int MIN_DELAY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        lfsr,
    input  logic              rand_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int       C_DMAX      = MIN_DELAY + (1 << RAND_W) - 1;
    localparam logic [7:0] C_RAND_MASK = 8'((1 << RAND_W) - 1);

    // The hold counter is 5 bits wide, so the worst-case delay must fit in it.
    if (RAND_W < 1 || RAND_W > 8 || MIN_DELAY < 0 || MIN_DELAY > 15 || C_DMAX > 31) begin : g_param_check
        $error("rand_delay_slice: illegal RAND_W/MIN_DELAY combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [7:0] w_rand;
    logic [8:0] w_delay_full;
    logic [4:0] w_delay;
    logic       w_unused;

    assign w_rand       = rand_en ? (lfsr & C_RAND_MASK) : 8'd0;
    assign w_delay_full = 9'(MIN_DELAY) + {1'b0, w_rand};
    assign w_delay      = w_delay_full[4:0];
    assign w_unused     = ^w_delay_full[8:5];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    if (w_delay == 5'd0) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = w_delay;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // All outputs come straight from registers: no input-to-output paths.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_SEND);
    assign out_data  = data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rand_delay_slice.sv
// ============================================================================
// Module      : tb_rand_delay_slice
// Description : Randomised scoreboard bench for rand_delay_slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rand_delay_slice;

    localparam int DATA_W    = 32;
    localparam int RAND_W    = 3;
    localparam int MIN_DELAY = 0;
    localparam int N_SWEEP   = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        lfsr = 8'd0;
    logic              rand_en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    rand_delay_slice #(
        .DATA_W   (DATA_W),
        .RAND_W   (RAND_W),
        .MIN_DELAY(MIN_DELAY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lfsr     (lfsr),
        .rand_en  (rand_en),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } beat_t;

    beat_t             sb_q[$];
    logic [DATA_W-1:0] exp_data = '0;
    int                cyc      = 0;
    int                total    = 0;
    int                bad      = 0;
    int                n_acc    = 0;
    int                n_out    = 0;
    bit                sweep_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // Reference model: one beat in flight, released 1 + d cycles after the
    // cycle in which it was accepted, with d fixed at acceptance.
    always @(negedge clk) begin
        bit exp_busy, exp_valid;
        int d;
        if (rst) begin
            sb_q.delete();
            exp_data = '0;
        end else begin
            exp_busy  = (sb_q.size() != 0);
            exp_valid = exp_busy && (cyc >= sb_q[0].due);
            chk("in_ready", DATA_W'(in_ready), DATA_W'(!exp_busy));
            chk("busy", DATA_W'(busy), DATA_W'(exp_busy));
            chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_valid));
            chk("out_data", out_data, exp_data);
            if (in_valid && !exp_busy) begin
                d = MIN_DELAY + (rand_en ? (int'(lfsr) % (1 << RAND_W)) : 0);
                sb_q.push_back('{data: in_data, due: cyc + 1 + d});
                exp_data = in_data;
                n_acc++;
            end else if (exp_valid && out_ready) begin
                void'(sb_q.pop_front());
                n_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (sweep_on) begin
            lfsr      = lfsr_next(lfsr);
            out_ready = ($urandom % 4) != 0;
        end
    endtask

    task automatic wait_accept(input string name);
        int start = n_acc;
        int k = 0;
        while (n_acc == start && k < 100) begin
            step();
            k++;
        end
        if (n_acc == start) begin
            total++;
            bad++;
            $display("FAIL %s: no accept within %0d cycles", name, k);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            step();
            k++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d beats still pending, want 0", name, sb_q.size());
        end
    endtask

    initial begin
        int k;
        int out_start;

        // Reset, then idle.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();

        // Fixed latency.
        rand_en   = 1'b0;
        lfsr      = 8'hA7;
        out_ready = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_valid  = 1'b1;
        wait_accept("fixed_accept");
        in_valid = 1'b0;
        repeat (4) step();

        // Random delay; lfsr changes during the hold must not matter.
        rand_en  = 1'b1;
        lfsr     = 8'b0000_0101;
        in_data  = 32'hCAFE0005;
        in_valid = 1'b1;
        wait_accept("rand_accept");
        in_valid = 1'b0;
        lfsr     = 8'hFF;
        repeat (10) step();

        // Backpressure with a second beat waiting.
        lfsr      = 8'd2;
        out_ready = 1'b0;
        in_data   = 32'hA5A5_0001;
        in_valid  = 1'b1;
        wait_accept("bp_first");
        in_data = 32'hA5A5_0002;
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        repeat (4) step();
        out_ready = 1'b1;
        wait_accept("bp_second");
        in_valid = 1'b0;
        drain("bp_drain");
        repeat (2) step();

        // Reset while holding a beat.
        lfsr     = 8'd7;
        in_data  = 32'h12345678;
        in_valid = 1'b1;
        wait_accept("rst_accept");
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (12) step();

        // Random sweep driven by a free-running LFSR.
        out_start = n_out;
        lfsr      = 8'h01;
        rand_en   = 1'b1;
        sweep_on  = 1'b1;
        for (int i = 0; i < N_SWEEP; i++) begin
            in_data  = $urandom;
            in_valid = 1'b1;
            wait_accept("sweep_accept");
        end
        in_valid = 1'b0;
        drain("sweep_drain");
        sweep_on = 1'b0;
        chk("sweep_count", DATA_W'(n_out - out_start), DATA_W'(N_SWEEP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
